// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor: partial tag, stored target and 2-bit counter per entry.
// Define BP_STATS_EN to add registered branch / mispredict statistics counters.
`ifndef AddrLen
`define AddrLen 32
`endif

module branch_predictor #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [`AddrLen-1:0] pc,
  output logic                jump_predict,
  output logic [`AddrLen-1:0] predict_target,
  input  logic                upd_valid,
  input  logic [`AddrLen-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [`AddrLen-1:0] upd_target,
  input  logic                upd_mistake
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int unsigned Entries = 2 ** IDX_W;
  localparam int unsigned TagLo   = IDX_W + 2;
  localparam int unsigned TagHi   = IDX_W + TAG_W + 1;

  logic [Entries-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q    [Entries];
  logic [`AddrLen-1:0] target_q [Entries];
  logic [1:0]          cnt_q    [Entries];

  // Lookup: purely combinational, reads pre-update contents (no bypass).
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx         = pc[IDX_W+1:2];
  assign lk_tag         = pc[TagHi:TagLo];
  assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign jump_predict   = lk_hit && cnt_q[lk_idx][1];
  assign predict_target = jump_predict ? target_q[lk_idx] : pc + `AddrLen'd4;

  // Training
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_en;
  logic             up_hit;
  logic             wr_en;
  logic [1:0]       cnt_cur;
  logic [1:0]       cnt_d;

  assign up_idx  = upd_pc[IDX_W+1:2];
  assign up_tag  = upd_pc[TagHi:TagLo];
  assign up_en   = rst && rdy && upd_valid;
  assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign cnt_cur = cnt_q[up_idx];

  always_comb begin
    wr_en = 1'b0;
    cnt_d = cnt_cur;
    if (up_en) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          cnt_d = (cnt_cur == 2'b11) ? 2'b11 : cnt_cur + 2'd1;
        end else begin
          cnt_d = (cnt_cur == 2'b00) ? 2'b00 : cnt_cur - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocate only on taken; a fresh entry starts weakly taken.
        wr_en = 1'b1;
        cnt_d = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < Entries; i++) begin
        cnt_q[i]    <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (wr_en) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      cnt_q[up_idx]   <= cnt_d;
      if (upd_taken) begin
        target_q[up_idx] <= upd_target;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (up_en) begin
      stat_branches <= stat_branches + 32'd1;
      if (upd_mistake) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

  // Address bits outside index/tag, and upd_mistake in the default build, are not used.
  logic unused_bits;
  assign unused_bits = ^{pc[1:0], pc[`AddrLen-1:TagHi+1], upd_pc[1:0],
                         upd_pc[`AddrLen-1:TagHi+1], upd_mistake};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed plan scenarios plus randomized
// traffic checked against an array-based reference model (stats checked if BP_STATS_EN).
module tb_branch_predictor;

  localparam int unsigned IDX_W   = 6;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned ENTRIES = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        jump_predict;
  logic [31:0] predict_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic        upd_mistake = 1'b0;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .pc            (pc),
    .jump_predict  (jump_predict),
    .predict_target(predict_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_mistake   (upd_mistake)
`ifdef BP_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  // Reference model: one record per table slot, counter kept as a plain integer 0..3.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  int unsigned m_br;
  int unsigned m_mp;

  function automatic int unsigned idx_of(logic [31:0] a);
    return (a / 32'd4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] a);
    return (a / (32'd4 * ENTRIES)) % (32'd1 << TAG_W);
  endfunction

  function automatic bit exp_jump(logic [31:0] a);
    int unsigned i = idx_of(a);
    return m_valid[i] && (m_tag[i] == tag_of(a)) && (m_cnt[i] >= 2);
  endfunction

  function automatic logic [31:0] exp_tgt(logic [31:0] a);
    logic [31:0] seq = a + 32'd4;
    return exp_jump(a) ? m_tgt[idx_of(a)] : seq;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'h0;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic model_update(logic [31:0] a, bit tk, logic [31:0] tg, bit mis);
    int unsigned i = idx_of(a);
    m_br++;
    if (mis) m_mp++;
    if (m_valid[i] && m_tag[i] == tag_of(a)) begin
      if (tk) begin
        m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
        m_tgt[i] = tg;
      end else begin
        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(a);
      m_tgt[i]   = tg;
      m_cnt[i]   = 2;
    end
  endtask

  // Advance one clock; the model trains on the same edge as the DUT would.
  task automatic tick();
    @(posedge clk);
    if (rst && rdy && upd_valid) model_update(upd_pc, upd_taken, upd_target, upd_mistake);
    #1;
  endtask

  task automatic apply_upd(logic [31:0] a, bit tk, logic [31:0] tg, bit mis);
    upd_valid   = 1'b1;
    upd_pc      = a;
    upd_taken   = tk;
    upd_target  = tg;
    upd_mistake = mis;
    tick();
    upd_valid   = 1'b0;
    upd_mistake = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    pc  = 32'h0000_0100;
    #2;
    n_vec++;
    if ({jump_predict, predict_target} !== {1'b0, 32'h0000_0104}) begin
      n_err++;
      $display("FAIL reset_hold: got %0b/%h want 0/00000104", jump_predict, predict_target);
    end
    pc = 32'hFFFF_FFFC;
    #1;
    n_vec++;
    if ({jump_predict, predict_target} !== {1'b0, 32'h0000_0000}) begin
      n_err++;
      $display("FAIL pc_wrap: got %0b/%h want 0/00000000", jump_predict, predict_target);
    end
    pc = 32'h0000_0100;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if ({jump_predict, predict_target} !== {1'b0, 32'h0000_0104}) begin
        n_err++;
        $display("FAIL reset_idle%0d: got %0b/%h want 0/00000104", k, jump_predict,
                 predict_target);
      end
    end
  endtask

  task automatic test_train();
    logic [32:0] want [4];
    bit          tk   [4];
    want[0] = {1'b1, 32'h0000_0200}; tk[0] = 1'b1;
    want[1] = {1'b0, 32'h0000_0104}; tk[1] = 1'b0;
    want[2] = {1'b0, 32'h0000_0104}; tk[2] = 1'b0;
    want[3] = {1'b0, 32'h0000_0104}; tk[3] = 1'b1;
    pc = 32'h0000_0100;
    for (int k = 0; k < 4; k++) begin
      apply_upd(32'h0000_0100, tk[k], 32'h0000_0200, 1'b0);
      n_vec++;
      if ({jump_predict, predict_target} !== want[k]) begin
        n_err++;
        $display("FAIL train_step%0d: got %0b/%h want %0b/%h", k, jump_predict,
                 predict_target, want[k][32], want[k][31:0]);
      end
    end
  endtask

  task automatic test_alias();
    pc = 32'h0000_0100;
    apply_upd(32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0);
    n_vec++;
    if ({jump_predict, predict_target} !== {1'b1, 32'h0000_0200}) begin
      n_err++;
      $display("FAIL alias_pre: got %0b/%h want 1/00000200", jump_predict, predict_target);
    end
    apply_upd(32'h0000_0100 + (32'd1 << (IDX_W + 2)), 1'b1, 32'h0000_0300, 1'b0);
    #1;
    n_vec++;
    if ({jump_predict, predict_target} !== {1'b0, 32'h0000_0104}) begin
      n_err++;
      $display("FAIL alias_evicted: got %0b/%h want 0/00000104", jump_predict, predict_target);
    end
    pc = 32'h0000_0200;
    #1;
    n_vec++;
    if ({jump_predict, predict_target} !== {1'b1, 32'h0000_0300}) begin
      n_err++;
      $display("FAIL alias_new: got %0b/%h want 1/00000300", jump_predict, predict_target);
    end
  endtask

  task automatic test_rdy();
    rdy = 1'b0;
    apply_upd(32'h0000_0040, 1'b1, 32'h0000_0080, 1'b0);
    apply_upd(32'h0000_0200, 1'b1, 32'h0000_0999, 1'b0);
    pc = 32'h0000_0040;
    #1;
    n_vec++;
    if ({jump_predict, predict_target} !== {1'b0, 32'h0000_0044}) begin
      n_err++;
      $display("FAIL rdy_no_alloc: got %0b/%h want 0/00000044", jump_predict, predict_target);
    end
    pc = 32'h0000_0200;
    #1;
    n_vec++;
    if ({jump_predict, predict_target} !== {1'b1, 32'h0000_0300}) begin
      n_err++;
      $display("FAIL rdy_no_retarget: got %0b/%h want 1/00000300", jump_predict, predict_target);
    end
    rdy = 1'b1;
  endtask

  task automatic test_same_cycle();
    pc          = 32'h0000_0200;
    upd_valid   = 1'b1;
    upd_pc      = 32'h0000_0200;
    upd_taken   = 1'b1;
    upd_target  = 32'h0000_0400;
    #1;
    n_vec++;
    if ({jump_predict, predict_target} !== {1'b1, 32'h0000_0300}) begin
      n_err++;
      $display("FAIL same_cycle_old: got %0b/%h want 1/00000300", jump_predict, predict_target);
    end
    tick();
    upd_valid = 1'b0;
    n_vec++;
    if ({jump_predict, predict_target} !== {1'b1, 32'h0000_0400}) begin
      n_err++;
      $display("FAIL same_cycle_new: got %0b/%h want 1/00000400", jump_predict, predict_target);
    end
  endtask

  task automatic test_async_reset();
    pc = 32'h0000_0200;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({jump_predict, predict_target} !== {1'b0, 32'h0000_0204}) begin
      n_err++;
      $display("FAIL async_reset: got %0b/%h want 0/00000204", jump_predict, predict_target);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_vec++;
    if ({jump_predict, predict_target} !== {1'b0, 32'h0000_0204}) begin
      n_err++;
      $display("FAIL async_reset_after: got %0b/%h want 0/00000204", jump_predict,
               predict_target);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int k = 0; k < 400; k++) begin
      // Small address pool so entries get hit, trained, aliased and evicted.
      a = {22'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'b00};
      b = {22'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 15) == 0) a = $urandom & 32'hFFFF_FFFC;
      pc          = a;
      rdy         = ($urandom_range(0, 9) != 0);
      upd_valid   = $urandom_range(0, 1);
      upd_pc      = b;
      upd_taken   = ($urandom_range(0, 2) != 0);
      upd_target  = $urandom & 32'hFFFF_FFFC;
      upd_mistake = $urandom_range(0, 1);
      #1;
      n_vec++;
      if ({jump_predict, predict_target} !== {exp_jump(pc), exp_tgt(pc)}) begin
        n_err++;
        $display("FAIL random%0d pc=%h: got %0b/%h want %0b/%h", k, pc, jump_predict,
                 predict_target, exp_jump(pc), exp_tgt(pc));
      end
      tick();
    end
    upd_valid   = 1'b0;
    upd_mistake = 1'b0;
    rdy         = 1'b1;
`ifdef BP_STATS_EN
    n_vec++;
    if ({stat_branches, stat_mispredicts} !== {m_br, m_mp}) begin
      n_err++;
      $display("FAIL random_stats: got %0d/%0d want %0d/%0d", stat_branches, stat_mispredicts,
               m_br, m_mp);
    end
`endif
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({stat_branches, stat_mispredicts} !== 64'h0) begin
      n_err++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      apply_upd(32'h0000_1000 + 32'(k * 4), k[0], 32'h0000_2000, (k == 1) || (k == 4));
    end
    rdy = 1'b0;
    apply_upd(32'h0000_1000, 1'b1, 32'h0000_2000, 1'b1);
    rdy = 1'b1;
    upd_mistake = 1'b1;
    tick();
    upd_mistake = 1'b0;
    n_vec++;
    if ({stat_branches, stat_mispredicts} !== {32'd5, 32'd2}) begin
      n_err++;
      $display("FAIL stats_count: got %0d/%0d want 5/2", stat_branches, stat_mispredicts);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({stat_branches, stat_mispredicts} !== 64'h0) begin
      n_err++;
      $display("FAIL stats_clear: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_train();
    test_alias();
    test_rdy();
    test_same_cycle();
    test_async_reset();
    test_random();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
